// File: rtl/spi_xfer_ctrl_if.sv
// Handshake and control bundle between the SPI transfer controller and its
// CPU-side register block / shifter.
interface spi_xfer_ctrl_if;
  logic spe;
  logic start;
  logic cpol;
  logic spif_clr;
  logic SCK;
  logic SS_n;
  logic shifter_en;
  logic SPDR_rd_en;
  logic SPDR_wr_en;
  logic SPIF;
  logic WCOL;
  logic busy;

  modport slave (
    input  spe, start, cpol, spif_clr,
    output SCK, SS_n, shifter_en, SPDR_rd_en, SPDR_wr_en, SPIF, WCOL, busy
  );

  modport master (
    output spe, start, cpol, spif_clr,
    input  SCK, SS_n, shifter_en, SPDR_rd_en, SPDR_wr_en, SPIF, WCOL, busy
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: load, shift DWIDTH bits on SCK, commit, flag.
// Write-collision detection is built only when SPI_WCOL_DETECT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start with spe high; SCK follows cpol
// LOAD  | one cycle: shifter loaded from SPDR, cpol latched, counters cleared
// SHIFT | SCK toggles every CLK_DIV cycles for DWIDTH full pulses
// DONE  | one cycle: received word committed, SPIF set
module spi_xfer_ctrl #(
  parameter int DWIDTH  = 8,
  parameter int CLK_DIV = 4
) (
  input logic             Sample_clk,
  input logic             rst,
  spi_xfer_ctrl_if.slave  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_q;
  logic               sck_q;
  logic               cpol_q;
  logic               spif_q;
  logic               run_q;
  logic               div_tc;
  logic               trail_edge;
  logic               last_edge;

  logic sck_d;
  logic ss_n_d;
  logic shifter_en_d;
  logic rd_en_d;
  logic wr_en_d;

  assign div_tc     = (div_q == DIV_W'(CLK_DIV - 1));
  assign trail_edge = div_tc && (sck_q != cpol_q);
  assign last_edge  = trail_edge && (bit_q == BIT_W'(DWIDTH - 1));

  always_ff @(posedge Sample_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sck_d        = run_q ? bus.cpol : 1'b0;
    ss_n_d       = 1'b1;
    shifter_en_d = 1'b0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.spe && bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ss_n_d  = 1'b0;
        rd_en_d = 1'b1;
        state_d = bus.spe ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        ss_n_d       = 1'b0;
        shifter_en_d = 1'b1;
        sck_d        = sck_q;
        if (!bus.spe)      state_d = S_IDLE;
        else if (last_edge) state_d = S_DONE;
      end
      S_DONE: begin
        wr_en_d = 1'b1;
        sck_d   = cpol_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider and bit counter only run inside SHIFT; LOAD re-arms them.
  always_ff @(posedge Sample_clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      bit_q  <= '0;
      sck_q  <= 1'b0;
      cpol_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        S_LOAD: begin
          div_q  <= '0;
          bit_q  <= '0;
          cpol_q <= bus.cpol;
          sck_q  <= bus.cpol;
        end
        S_SHIFT: begin
          if (div_tc) begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (trail_edge) bit_q <= bit_q + BIT_W'(1);
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Sample_clk or negedge rst) begin
    if (!rst) begin
      spif_q <= 1'b0;
    end else if (state_q == S_DONE) begin
      spif_q <= 1'b1;
    end else if (bus.spif_clr) begin
      spif_q <= 1'b0;
    end
  end

`ifdef SPI_WCOL_DETECT_EN
  logic wcol_q;

  always_ff @(posedge Sample_clk or negedge rst) begin
    if (!rst) begin
      wcol_q <= 1'b0;
    end else if (bus.start && (state_q != S_IDLE)) begin
      wcol_q <= 1'b1;
    end else if (bus.spif_clr) begin
      wcol_q <= 1'b0;
    end
  end

  assign bus.WCOL = wcol_q;
`else
  assign bus.WCOL = 1'b0;
`endif

  // SPIF is visible in the DONE cycle itself, then held by the register.
  assign bus.SPIF       = spif_q | (state_q == S_DONE);
  assign bus.SCK        = sck_d;
  assign bus.SS_n       = ss_n_d;
  assign bus.shifter_en = shifter_en_d;
  assign bus.SPDR_rd_en = rd_en_d;
  assign bus.SPDR_wr_en = wr_en_d;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: two instances (CLK_DIV 4 and 1) against an
// offset-arithmetic reference model, plus directed literal checks.
module tb_spi_xfer_ctrl;

  localparam int DW = 8;
  localparam int K0 = 4;
  localparam int K1 = 1;
  // output vector bit positions
  localparam int B_SCK = 7, B_SSN = 6, B_SH = 5, B_RD = 4, B_WR = 3,
                 B_SPIF = 2, B_WCOL = 1, B_BUSY = 0;

`ifdef SPI_WCOL_DETECT_EN
  localparam logic WCOL_ON = 1'b1;
`else
  localparam logic WCOL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic spe, start, cpol, spif_clr;

  int n_chk  = 0;
  int n_fail = 0;

  spi_xfer_ctrl_if b0 ();
  spi_xfer_ctrl_if b1 ();

  assign b0.spe = spe;  assign b0.start = start;  assign b0.cpol = cpol;  assign b0.spif_clr = spif_clr;
  assign b1.spe = spe;  assign b1.start = start;  assign b1.cpol = cpol;  assign b1.spif_clr = spif_clr;

  spi_xfer_ctrl #(.DWIDTH(DW), .CLK_DIV(K0)) u0 (.Sample_clk(clk), .rst(rst), .bus(b0));
  spi_xfer_ctrl #(.DWIDTH(DW), .CLK_DIV(K1)) u1 (.Sample_clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  logic [7:0] o [2];
  assign o[0] = {b0.SCK, b0.SS_n, b0.shifter_en, b0.SPDR_rd_en, b0.SPDR_wr_en, b0.SPIF, b0.WCOL, b0.busy};
  assign o[1] = {b1.SCK, b1.SS_n, b1.shifter_en, b1.SPDR_rd_en, b1.SPDR_wr_en, b1.SPIF, b1.WCOL, b1.busy};

  // ---------------- reference model ----------------
  int   cyc = 0;
  logic m_act [2];
  int   m_t0  [2];
  logic m_cpl [2];
  logic m_spif[2];
  logic m_wcol[2];
  logic m_run;

  function automatic int kdiv(int i);
    return (i == 0) ? K0 : K1;
  endfunction

  // 0 idle, 1 load, 2 shift, 3 done -- derived from offset since start
  function automatic int ph(int i);
    int off;
    if (!m_act[i]) return 0;
    off = cyc - m_t0[i];
    if (off == 1) return 1;
    if (off <= 1 + 2 * DW * kdiv(i)) return 2;
    return 3;
  endfunction

  function automatic logic [7:0] exp_v(int i);
    int   off;
    logic sck;
    off = cyc - m_t0[i];
    case (ph(i))
      1: return {cpol, 1'b0, 1'b0, 1'b1, 1'b0, m_spif[i], m_wcol[i], 1'b1};
      2: begin
        sck = m_cpl[i] ^ ((((off - 2) / kdiv(i)) % 2) == 1);
        return {sck, 1'b0, 1'b1, 1'b0, 1'b0, m_spif[i], m_wcol[i], 1'b1};
      end
      3: return {m_cpl[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, m_wcol[i], 1'b1};
      default: return {m_run ? cpol : 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_spif[i], m_wcol[i], 1'b0};
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]  <= 1'b0;
        m_t0[i]   <= 0;
        m_cpl[i]  <= 1'b0;
        m_spif[i] <= 1'b0;
        m_wcol[i] <= 1'b0;
      end
      m_run <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int p;
        p = ph(i);
        if (p == 3) m_spif[i] <= 1'b1;
        else if (spif_clr) m_spif[i] <= 1'b0;
        if (WCOL_ON && start && p != 0) m_wcol[i] <= 1'b1;
        else if (spif_clr) m_wcol[i] <= 1'b0;
        if (p == 0 && start && spe) begin
          m_act[i] <= 1'b1;
          m_t0[i]  <= cyc;
        end
        if (p == 1) m_cpl[i] <= cpol;
        if ((p == 1 || p == 2) && !spe) m_act[i] <= 1'b0;
        if (p == 3) m_act[i] <= 1'b0;
      end
      m_run <= 1'b1;
      cyc   <= cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // per-cycle comparison of every output of both instances
  always @(negedge clk) begin
    #1;
    chk("outs_div4", {24'd0, o[0]}, {24'd0, exp_v(0)});
    chk("outs_div1", {24'd0, o[1]}, {24'd0, exp_v(1)});
  end

  task automatic step();
    @(negedge clk);
    start    = 1'b0;
    spif_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    logic prev;
    rst = 1'b0; spe = 1'b0; start = 1'b0; cpol = 1'b1; spif_clr = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_sck_low", {31'd0, o[0][B_SCK]}, 32'd0);
    chk("rst_ssn_high", {31'd0, o[0][B_SSN]}, 32'd1);
    step(); rst = 1'b1; spe = 1'b1; cpol = 1'b0;
    repeat (3) step();

    // single transfer, cpol=0; collision start at 30; spif_clr at 66 and 67
    step(); start = 1'b1;
    pulses = 0; prev = o[0][B_SCK];
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 30) start = 1'b1;
      if (k == 66 || k == 67) spif_clr = 1'b1;
      #1;
      if (k <= 66 && o[0][B_SCK] && !prev) pulses++;
      prev = o[0][B_SCK];
      if (k == 1)  chk("d1_rd_en_c1", {31'd0, o[0][B_RD]}, 32'd1);
      if (k == 18) chk("d1_div1_wr_c18", {31'd0, o[1][B_WR]}, 32'd1);
      if (k == 31) chk("d1_wcol_c31", {31'd0, o[0][B_WCOL]}, {31'd0, WCOL_ON});
      if (k == 65) chk("d1_ssn_c65", {31'd0, o[0][B_SSN]}, 32'd0);
      if (k == 66) chk("d1_wr_c66", {31'd0, o[0][B_WR]}, 32'd1);
      if (k == 66) chk("d1_spif_c66", {31'd0, o[0][B_SPIF]}, 32'd1);
      if (k == 67) chk("d1_spif_setwins", {31'd0, o[0][B_SPIF]}, 32'd1);
      if (k == 68) chk("d1_spif_cleared", {31'd0, o[0][B_SPIF]}, 32'd0);
    end
    chk("d1_sck_pulses", pulses, 32'd8);

    // cpol=1 transfer, spe dropped in cycle 20
    step(); spif_clr = 1'b1;
    step(); cpol = 1'b1;
    step(); start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      spe = (k == 20 || k == 21) ? 1'b0 : 1'b1;
      #1;
      if (k == 1)  chk("d2_div1_sck_idlehi", {31'd0, o[1][B_SCK]}, 32'd1);
      if (k == 17) chk("d2_div1_ssn_c17", {31'd0, o[1][B_SSN]}, 32'd0);
      if (k == 18) chk("d2_div1_wr_c18", {31'd0, o[1][B_WR]}, 32'd1);
      if (k == 21) chk("d2_abort_busy", {31'd0, o[0][B_BUSY]}, 32'd0);
      if (k == 21) chk("d2_abort_ssn", {31'd0, o[0][B_SSN]}, 32'd1);
      if (k == 21) chk("d2_abort_spif", {31'd0, o[0][B_SPIF]}, 32'd0);
      if (k == 21) chk("d2_abort_sck", {31'd0, o[0][B_SCK]}, 32'd1);
    end

    // reset at cycle 40 of a transfer, then a clean transfer
    step(); spif_clr = 1'b1; cpol = 1'b0;
    step(); start = 1'b1;
    for (int k = 1; k <= 40; k++) step();
    rst = 1'b0;
    #1;
    chk("d3_rst_outs", {24'd0, o[0]}, {24'd0, 8'b0100_0000});
    step(); rst = 1'b1;
    repeat (3) step();
    step(); start = 1'b1;
    for (int k = 1; k <= 66; k++) step();
    #1;
    chk("d3_after_rst_wr_c66", {31'd0, o[0][B_WR]}, 32'd1);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step();
      start    = ($urandom_range(0, 24) == 0);
      spif_clr = ($urandom_range(0, 19) == 0);
      spe      = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 29) == 0) cpol = ~cpol;
      rst      = ($urandom_range(0, 1499) != 0);
    end
    step(); rst = 1'b1;
    step();
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
